mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates a single-ported memory between an instruction-fetch port and a
//   data port, with at most one transaction in flight. The data port has
//   priority, but fetch is guaranteed a grant once it has waited through
//   STARVE_MAX consecutive data grants.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   if_req/if_addr        fetch request and address (held until if_gnt)
//   if_gnt/if_rvalid      one-cycle grant / read-data-valid pulses to fetch
//   if_rdata              last fetched word
//   d_req/d_we/d_addr     data request, write flag, address (held until d_gnt)
//   d_wdata               store data
//   d_gnt/d_rvalid        one-cycle grant / completion pulses to data port
//   d_rdata               last load data (unchanged by stores)
//   mem_en/mem_we         one-cycle memory strobe and write enable
//   mem_addr/mem_wdata    registered address and store data
//   mem_rdata             memory read data, valid MEM_LAT cycles after mem_en
//
// state  | meaning
// IDLE   | no transaction in flight; arbitrate this cycle
// BUSY_I | fetch read in flight, waiting for memory latency
// BUSY_D | data read or write in flight, waiting for memory latency

module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] LAT_LD     = 4'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] lat_cnt;
  logic [3:0] starve_cnt;
  logic       cur_we;
  logic       win_i;
  logic       win_d;
  logic       lat_tc;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (win_i)      state_nxt = BUSY_I;
        else if (win_d) state_nxt = BUSY_D;
      end
      BUSY_I, BUSY_D: begin
        if (lat_tc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // arbitration decision and latency terminal count
  always_comb begin
    win_i  = 1'b0;
    win_d  = 1'b0;
    lat_tc = (state != IDLE) && (lat_cnt == 4'd0);
    if (state == IDLE) begin
      // fetch wins outright when data is idle, or when it has been starved
      if (if_req && (!d_req || starve_cnt == STARVE_LIM)) win_i = 1'b1;
      else if (d_req)                                    win_d = 1'b1;
    end
  end

  // Registered outputs and datapath. The latency counter is loaded with
  // MEM_LAT in the grant cycle and reaches zero in the cycle where
  // mem_rdata is valid; that value is captured so rdata/rvalid appear
  // together one cycle later, which is also the next arbitration cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_gnt     <= 1'b0;
      d_gnt      <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rvalid  <= 1'b0;
      d_rvalid   <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      lat_cnt    <= 4'd0;
      starve_cnt <= 4'd0;
      cur_we     <= 1'b0;
    end else begin
      if_gnt <= win_i;
      d_gnt  <= win_d;
      mem_en <= win_i | win_d;
      mem_we <= win_d & d_we;

      if (win_i) begin
        mem_addr <= if_addr;
        cur_we   <= 1'b0;
      end
      if (win_d) begin
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        cur_we    <= d_we;
      end

      if (win_i || win_d)      lat_cnt <= LAT_LD;
      else if (lat_cnt != 4'd0) lat_cnt <= lat_cnt - 4'd1;

      if_rvalid <= lat_tc && (state == BUSY_I);
      d_rvalid  <= lat_tc && (state == BUSY_D);
      if (lat_tc && state == BUSY_I)            if_rdata <= mem_rdata;
      if (lat_tc && state == BUSY_D && !cur_we) d_rdata  <= mem_rdata;

      if (win_i)                               starve_cnt <= 4'd0;
      else if (state == IDLE && !if_req)       starve_cnt <= 4'd0;
      else if (win_d && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    int            cyc;
    bit            is_d;
    logic [AW-1:0] addr;
    bit            we;
    logic [DW-1:0] wdata;
  } gnt_t;

  typedef struct {
    int            cyc;
    bit            is_d;
    bit            we;
    logic [DW-1:0] data;
  } rv_t;

  gnt_t gq[$];
  rv_t  rq[$];

  // memory contents: a fixed function of the address
  function automatic logic [DW-1:0] memfun(input logic [AW-1:0] a);
    if (a == 64'h100) return 64'h0000_0000_0050_0093;
    return {a[31:0] ^ 32'hA5C3_0F1E, ~a[31:0]} ^ {a[63:32], a[63:32]};
  endfunction

  // ---------------- requester state + transaction-level reference model
  bit            i_pend = 0, d_pend = 0;
  logic [AW-1:0] i_addr_v = '0, d_addr_v = '0;
  bit            d_we_v = 0;
  logic [DW-1:0] d_wdata_v = '0;
  bit            rst_v = 1;
  bit            hold_both = 0, rand_mode = 0;
  int            next_arb = 0;
  int            starve = 0;

  task automatic new_i();
    i_pend   = 1;
    i_addr_v = {$urandom, $urandom};
  endtask

  task automatic new_d();
    d_pend    = 1;
    d_we_v    = 1'($urandom_range(0, 1));
    d_addr_v  = {$urandom, $urandom};
    d_wdata_v = {$urandom, $urandom};
  endtask

  // Memory is busy for LAT+2 cycles from the arbitration cycle; the port
  // that wins follows the priority/starvation rules, applied to integers.
  task automatic model();
    int   t;
    bit   wi, wd;
    gnt_t g;
    rv_t  r;
    t = cyc;
    if (reset) begin
      while (gq.size() > 0 && gq[$].cyc > t) void'(gq.pop_back());
      while (rq.size() > 0 && rq[$].cyc > t) void'(rq.pop_back());
      next_arb = t + 1;
      starve   = 0;
    end else if (t >= next_arb) begin
      wi = i_pend && (!d_pend || starve == SMAX);
      wd = !wi && d_pend;
      if (wi)          starve = 0;
      else if (!i_pend) starve = 0;
      else if (wd)     starve = (starve + 1 > SMAX) ? SMAX : starve + 1;
      if (wi || wd) begin
        g.cyc   = t + 1;
        g.is_d  = wd;
        g.addr  = wd ? d_addr_v : i_addr_v;
        g.we    = wd && d_we_v;
        g.wdata = d_wdata_v;
        gq.push_back(g);
        r.cyc  = t + 2 + LAT;
        r.is_d = wd;
        r.we   = g.we;
        r.data = memfun(g.addr);
        rq.push_back(r);
        next_arb = t + 2 + LAT;
        if (wi) i_pend = 0;
        else    d_pend = 0;
      end
    end
  endtask

  task automatic tick();
    if (hold_both) begin
      if (!i_pend) new_i();
      if (!d_pend) new_d();
    end else if (rand_mode) begin
      if (!i_pend && $urandom_range(0, 3) == 0) new_i();
      if (!d_pend && $urandom_range(0, 2) == 0) new_d();
      rst_v = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    reset   = rst_v;
    if_req  = i_pend;
    if_addr = i_pend ? i_addr_v : {$urandom, $urandom};
    d_req   = d_pend;
    d_we    = d_pend ? d_we_v : 1'($urandom_range(0, 1));
    d_addr  = d_pend ? d_addr_v : {$urandom, $urandom};
    d_wdata = d_pend ? d_wdata_v : {$urandom, $urandom};
    model();
  endtask

  // ---------------- memory responder
  int            resp_cyc = -1;
  logic [DW-1:0] resp_val = '0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cyc == resp_cyc) mem_rdata = resp_val;
      else                 mem_rdata = {$urandom, $urandom};
      if (mem_en && !mem_we && !reset) begin
        resp_cyc = cyc + LAT;
        resp_val = memfun(mem_addr);
      end
    end
  end

  // ---------------- monitor / scoreboard
  logic [DW-1:0] held_i = '0, held_d = '0;

  task automatic check();
    gnt_t          g;
    rv_t           r;
    logic [DW-1:0] got;
    if (reset) begin
      vectors++;
      if ({if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata} != '0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got gnt=%b%b rv=%b%b en=%b we=%b addr=%h wd=%h ird=%h drd=%h, required all zero",
                 cyc, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata);
      end
      held_i = '0;
      held_d = '0;
      return;
    end

    while (gq.size() > 0 && gq[0].cyc < cyc) begin
      g = gq.pop_front();
      vectors++; errors++;
      $display("FAIL missing_grant cyc=%0d got none, required grant at cyc=%0d", cyc, g.cyc);
    end
    if (if_gnt || d_gnt) begin
      vectors++;
      if (gq.size() == 0 || gq[0].cyc != cyc) begin
        errors++;
        $display("FAIL unexpected_grant cyc=%0d got if_gnt=%b d_gnt=%b, required no grant", cyc, if_gnt, d_gnt);
      end else begin
        g = gq.pop_front();
        if (d_gnt != g.is_d || if_gnt != !g.is_d || !mem_en || mem_addr != g.addr ||
            mem_we != g.we || (g.we && mem_wdata != g.wdata)) begin
          errors++;
          $display("FAIL grant cyc=%0d got d_gnt=%b en=%b addr=%h we=%b wd=%h, required d_gnt=%b en=1 addr=%h we=%b wd=%h",
                   cyc, d_gnt, mem_en, mem_addr, mem_we, mem_wdata, g.is_d, g.addr, g.we, g.wdata);
        end
      end
    end else if (gq.size() > 0 && gq[0].cyc == cyc) begin
      g = gq.pop_front();
      vectors++; errors++;
      $display("FAIL missing_grant cyc=%0d got none, required d_gnt=%b", cyc, g.is_d);
    end

    while (rq.size() > 0 && rq[0].cyc < cyc) begin
      r = rq.pop_front();
      vectors++; errors++;
      $display("FAIL missing_rvalid cyc=%0d got none, required rvalid at cyc=%0d", cyc, r.cyc);
    end
    if (if_rvalid || d_rvalid) begin
      vectors++;
      if (rq.size() == 0 || rq[0].cyc != cyc) begin
        errors++;
        $display("FAIL unexpected_rvalid cyc=%0d got if_rvalid=%b d_rvalid=%b, required none", cyc, if_rvalid, d_rvalid);
      end else begin
        r   = rq.pop_front();
        got = r.is_d ? d_rdata : if_rdata;
        if (d_rvalid != r.is_d || if_rvalid != !r.is_d ||
            (!r.we && got != r.data) || (r.we && d_rdata != held_d)) begin
          errors++;
          $display("FAIL rvalid cyc=%0d got d_rvalid=%b data=%h, required d_rvalid=%b we=%b data=%h",
                   cyc, d_rvalid, got, r.is_d, r.we, r.we ? held_d : r.data);
        end
        if (!r.we) begin
          if (r.is_d) held_d = r.data;
          else        held_i = r.data;
        end
      end
    end else if (rq.size() > 0 && rq[0].cyc == cyc) begin
      r = rq.pop_front();
      vectors++; errors++;
      $display("FAIL missing_rvalid cyc=%0d got none, required d_rvalid=%b", cyc, r.is_d);
    end

    vectors++;
    if (mem_en != (if_gnt | d_gnt) || (mem_we && !mem_en) || (if_gnt && d_gnt) || (if_rvalid && d_rvalid)) begin
      errors++;
      $display("FAIL strobes cyc=%0d got en=%b we=%b gnt=%b%b rv=%b%b, required en==gnt, we only with en, one-hot",
               cyc, mem_en, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid);
    end

    vectors++;
    if (if_rdata != held_i || d_rdata != held_d) begin
      errors++;
      $display("FAIL rdata_hold cyc=%0d got if_rdata=%h d_rdata=%h, required %h %h",
               cyc, if_rdata, d_rdata, held_i, held_d);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      check();
    end
  end

  // ---------------- stimulus
  initial begin
    rst_v = 1;
    repeat (3) tick();
    rst_v = 0;

    // single fetch
    i_pend = 1; i_addr_v = 64'h100;
    repeat (7) tick();

    // simultaneous fetch and data read
    i_pend = 1; i_addr_v = 64'h300;
    d_pend = 1; d_we_v = 0; d_addr_v = 64'h200; d_wdata_v = '0;
    repeat (12) tick();

    // store
    d_pend = 1; d_we_v = 1; d_addr_v = 64'h40; d_wdata_v = 64'hDEAD;
    repeat (6) tick();

    // both ports held busy: starvation bound
    hold_both = 1;
    repeat (80) tick();
    hold_both = 0;
    repeat (12) tick();

    // reset in the middle of a fetch, new request right after release
    i_pend = 1; i_addr_v = 64'h500;
    tick();
    tick();
    rst_v = 1;
    repeat (3) tick();
    rst_v = 0;
    i_pend = 1; i_addr_v = 64'h600;
    repeat (8) tick();

    // randomized traffic with occasional reset
    rand_mode = 1;
    repeat (3000) tick();
    rand_mode = 0;
    rst_v = 0;
    i_pend = 0; d_pend = 0;
    repeat (20) tick();

    vectors++;
    if (gq.size() != 0 || rq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d grants and %0d rvalids outstanding, required 0", gq.size(), rq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
